itch_message_framer: RTL
========================

Name: itch_message_framer

Overview:
- Upstream stage of market_data_processor.
- Consumes a length-prefixed ITCH byte stream, one byte per cycle, from the network/UDP payload extractor.
- Frames each message, extracts type, symbol and value, and buffers completed messages in a small FIFO.
- Drives the processor's data_valid/data_in/data_type/data_ready interface.

Parameters:
- FIFO_DEPTH, 8: assembled-message FIFO entries; power of 2, ≥2.
- SYM_OFFSET, 1: body byte index of symbol MSB (4 bytes, big-endian).
- VAL_OFFSET, 5: body byte index of value MSB (4 bytes, big-endian).
- MAX_MSG_LEN, 64: largest legal body length in bytes.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_last  in  1  last byte of transport packet
- s_ready  out  1  framer accepts byte this cycle
- data_valid  out  1  FIFO head valid, to processor
- data_in  out  64  {symbol[31:0], value[31:0]}
- data_type  out  8  ITCH message type byte
- data_ready  in  1  processor accepts head
- msg_count  out  32  messages pushed to FIFO
- drop_count  out  16  messages discarded
- err_flag  out  1  one-cycle error pulse
- err_code  out  8  code of last error, held

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - s_ready=0 while rst is high.
  - data_valid=0, data_in=0, data_type=0.
  - msg_count=0, drop_count=0, err_flag=0, err_code=0.
  - FIFO empty, FSM in LEN_HI.
- Reset mid-message discards the partial message and flushes the FIFO.
- Byte accept: s_valid && s_ready at a rising edge.
- s_ready = !rst && !(state==LEN_HI && fifo_full); backpressure applies only at message boundaries.
- FSM:
  - LEN_HI: store len[15:8]; go to LEN_LO.
  - LEN_LO: store len[7:0].
    - len==0: err 0x01, stay at boundary (LEN_HI).
    - len < VAL_OFFSET+4: err 0x02, go to DISCARD.
    - len > MAX_MSG_LEN: err 0x03, go to DISCARD.
    - Otherwise go to BODY with byte index idx=0.
  - BODY:
    - idx 0 captures type.
    - SYM_OFFSET..+3 shift into symbol.
    - VAL_OFFSET..+3 shift into value.
    - Other bytes are consumed and ignored.
    - On idx==len-1: push {type, symbol, value} to FIFO, return to LEN_HI.
  - DISCARD: consume len-2-... remaining body bytes (counter down to zero), drop_count+1, return to LEN_HI.
- s_last rules:
  - s_last on any byte that does not end a message (LEN_HI, LEN_LO, BODY before final byte): err 0x04, drop_count+1 (only if in BODY/DISCARD), no push, next state LEN_HI.
  - s_last on the final body byte is normal.
- Latency: last body byte accepted at edge N → data_valid=1 after edge N+1 (FIFO previously empty); data_in/data_type stable while data_valid && !data_ready.
- FIFO:
  - Pop on data_valid && data_ready.
  - Simultaneous push and pop when full is legal (count unchanged).
  - Push while full cannot occur, by s_ready gating.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - msg_count +1 per push, wraps at 2^32.
  - drop_count saturates at 0xFFFF.
- Errors: err_flag pulses 1 cycle in the cycle after the offending byte edge; err_code updates with it and holds. At most one error per byte.

Optional Feature:
- Macro: ITCH_TYPE_FILTER_EN.
- Defined: at message completion, types other than 0x41 'A', 0x45 'E', 0x58 'X', 0x44 'D' are not pushed; drop_count+1, err 0x05.
- Undefined: every well-formed message is pushed regardless of type; invalid types are left for the processor to flag.

Test Plan:
- Basic message:
  - Stimulus: bytes 00 09 41 41 41 50 54 64 00 00 00, data_ready=1.
  - Response: data_valid one cycle after the last byte; data_type=0x41; data_in=0x4141505464000000; msg_count=1.
- Backpressure:
  - Stimulus: data_ready=0; 9 back-to-back 9-byte messages with FIFO_DEPTH=8.
  - Response: s_ready=0 at the 9th LEN_HI; no drop.
  - Then data_ready=1: 9 messages emerge in order; msg_count=9, drop_count=0.
- Short length:
  - Stimulus: length 00 05 + 5 bytes, then a valid message.
  - Response: err_code=0x02, drop_count=1; the following message is output correctly (resync).
- Truncation:
  - Stimulus: s_last on body byte 4 of a 9-byte message.
  - Response: err_code=0x04, no push, drop_count=1; the next packet's message is framed from its first byte.
- Filter:
  - Stimulus: type 0xFF message.
  - Response, ITCH_TYPE_FILTER_EN defined: no data_valid; err_code=0x05; drop_count+1.
  - Response, undefined: forwarded with data_type=0xFF.
- Mid-message reset:
  - Stimulus: rst=1 for 1 cycle after 4 body bytes with 2 messages queued.
  - Response: data_valid=0 and counters 0 next cycle; a fresh message frames correctly.

Source files
------------

// File: rtl/itch_message_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// itch_message_framer
//
// Frames a length-prefixed ITCH byte stream, one byte per cycle. Each message
// is a 16-bit big-endian body length followed by the body. From the body it
// takes the type byte, a 4-byte symbol and a 4-byte value. Completed messages
// are queued in a small FIFO. The FIFO head feeds the market data processor
// through a valid/ready interface.
//
// Optional feature macro: ITCH_TYPE_FILTER_EN
//   When defined, completed messages whose type is not 'A', 'E', 'X' or 'D'
//   are dropped with error 0x05. When undefined, every well-formed message is
//   forwarded.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   s_valid     in   input byte valid
//   s_data      in   input byte [7:0]
//   s_last      in   last byte of transport packet
//   s_ready     out  framer accepts byte this cycle
//   data_valid  out  FIFO head valid
//   data_in     out  {symbol[31:0], value[31:0]} of FIFO head
//   data_type   out  ITCH type byte of FIFO head
//   data_ready  in   processor accepts head
//   msg_count   out  messages pushed to FIFO (wraps)
//   drop_count  out  messages discarded (saturates)
//   err_flag    out  one-cycle error pulse
//   err_code    out  code of last error, held
//
// Error codes: 0x01 zero length, 0x02 too short, 0x03 too long,
//              0x04 packet ended mid-message, 0x05 type filtered.
// -----------------------------------------------------------------------------
module itch_message_framer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYM_OFFSET  = 1,
  parameter int VAL_OFFSET  = 5,
  parameter int MAX_MSG_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        data_valid,
  output logic [63:0] data_in,
  output logic [7:0]  data_type,
  input  logic        data_ready,
  output logic [31:0] msg_count,
  output logic [15:0] drop_count,
  output logic        err_flag,
  output logic [7:0]  err_code
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [15:0]      MIN_LEN_C = 16'(VAL_OFFSET + 4);
  localparam logic [15:0]      MAX_LEN_C = 16'(MAX_MSG_LEN);
  localparam logic [15:0]      SYM_LO_C  = 16'(SYM_OFFSET);
  localparam logic [15:0]      SYM_HI_C  = 16'(SYM_OFFSET + 3);
  localparam logic [15:0]      VAL_LO_C  = 16'(VAL_OFFSET);
  localparam logic [15:0]      VAL_HI_C  = 16'(VAL_OFFSET + 3);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    LEN_HI  = 2'd0,
    LEN_LO  = 2'd1,
    BODY    = 2'd2,
    DISCARD = 2'd3
  } state_t;

`ifdef ITCH_TYPE_FILTER_EN
  // Message types the downstream processor understands.
  function automatic logic type_allowed(input logic [7:0] t);
    case (t)
      8'h41, 8'h45, 8'h58, 8'h44: type_allowed = 1'b1;
      default:                    type_allowed = 1'b0;
    endcase
  endfunction
`endif

  // Framing registers
  state_t      state_r;
  logic [7:0]  len_hi_r;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic [15:0] disc_cnt_r;
  logic [7:0]  type_r;
  logic [31:0] sym_r;
  logic [31:0] val_r;

  // Framing next-state values
  state_t      state_nx_s;
  logic [7:0]  len_hi_nx_s;
  logic [15:0] len_nx_s;
  logic [15:0] idx_nx_s;
  logic [15:0] disc_cnt_nx_s;
  logic [7:0]  type_nx_s;
  logic [31:0] sym_nx_s;
  logic [31:0] val_nx_s;
  logic        push_s;
  logic        drop_s;
  logic        err_s;
  logic [7:0]  err_code_s;

  logic        s_ready_s;
  logic        accept_s;
  logic [15:0] len_full_s;
  logic [71:0] entry_s;

  // FIFO storage plus a registered output slot holding the head
  logic [71:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] mem_cnt_r;
  logic             out_valid_r;
  logic [63:0]      out_data_r;
  logic [7:0]       out_type_r;
  logic             pop_s;
  logic             load_s;
  logic [CNT_W-1:0] occupancy_s;
  logic             fifo_full_s;

  logic [31:0] msg_count_r;
  logic [15:0] drop_count_r;
  logic        err_flag_r;
  logic [7:0]  err_code_r;

  // Occupancy counts the output slot too, so FIFO_DEPTH messages fill it.
  assign occupancy_s = mem_cnt_r + {{PTR_W{1'b0}}, out_valid_r};
  assign fifo_full_s = (occupancy_s == DEPTH_C);

  // Backpressure only at a message boundary: a started message always fits.
  assign s_ready_s  = !rst && !((state_r == LEN_HI) && fifo_full_s);
  assign accept_s   = s_valid && s_ready_s;
  assign len_full_s = {len_hi_r, s_data};
  assign entry_s    = {type_nx_s, sym_nx_s, val_nx_s};

  assign pop_s  = out_valid_r && data_ready;
  assign load_s = (mem_cnt_r != {CNT_W{1'b0}}) && (!out_valid_r || pop_s);

  // Framing FSM next state, field capture and error/push/drop decisions.
  always_comb begin
    state_nx_s    = state_r;
    len_hi_nx_s   = len_hi_r;
    len_nx_s      = len_r;
    idx_nx_s      = idx_r;
    disc_cnt_nx_s = disc_cnt_r;
    type_nx_s     = type_r;
    sym_nx_s      = sym_r;
    val_nx_s      = val_r;
    push_s        = 1'b0;
    drop_s        = 1'b0;
    err_s         = 1'b0;
    err_code_s    = 8'h00;
    if (accept_s) begin
      case (state_r)
        LEN_HI: begin
          if (s_last) begin
            err_s      = 1'b1;
            err_code_s = 8'h04;
            state_nx_s = LEN_HI;
          end else begin
            len_hi_nx_s = s_data;
            state_nx_s  = LEN_LO;
          end
        end
        LEN_LO: begin
          len_nx_s = len_full_s;
          if (s_last) begin
            err_s      = 1'b1;
            err_code_s = 8'h04;
            state_nx_s = LEN_HI;
          end else if (len_full_s == 16'd0) begin
            err_s      = 1'b1;
            err_code_s = 8'h01;
            state_nx_s = LEN_HI;
          end else if (len_full_s < MIN_LEN_C) begin
            err_s         = 1'b1;
            err_code_s    = 8'h02;
            disc_cnt_nx_s = len_full_s - 16'd1;
            state_nx_s    = DISCARD;
          end else if (len_full_s > MAX_LEN_C) begin
            err_s         = 1'b1;
            err_code_s    = 8'h03;
            disc_cnt_nx_s = len_full_s - 16'd1;
            state_nx_s    = DISCARD;
          end else begin
            idx_nx_s   = 16'd0;
            state_nx_s = BODY;
          end
        end
        BODY: begin
          if (idx_r == 16'd0) begin
            type_nx_s = s_data;
          end else begin
            type_nx_s = type_r;
          end
          if ((idx_r >= SYM_LO_C) && (idx_r <= SYM_HI_C)) begin
            sym_nx_s = {sym_r[23:0], s_data};
          end else begin
            sym_nx_s = sym_r;
          end
          if ((idx_r >= VAL_LO_C) && (idx_r <= VAL_HI_C)) begin
            val_nx_s = {val_r[23:0], s_data};
          end else begin
            val_nx_s = val_r;
          end
          idx_nx_s = idx_r + 16'd1;
          // Final body byte wins over s_last: a packet may end on it.
          if (idx_r == (len_r - 16'd1)) begin
            state_nx_s = LEN_HI;
`ifdef ITCH_TYPE_FILTER_EN
            if (type_allowed(type_nx_s)) begin
              push_s = 1'b1;
            end else begin
              drop_s     = 1'b1;
              err_s      = 1'b1;
              err_code_s = 8'h05;
            end
`else
            push_s = 1'b1;
`endif
          end else if (s_last) begin
            drop_s     = 1'b1;
            err_s      = 1'b1;
            err_code_s = 8'h04;
            state_nx_s = LEN_HI;
          end else begin
            state_nx_s = BODY;
          end
        end
        DISCARD: begin
          if (disc_cnt_r == 16'd0) begin
            drop_s     = 1'b1;
            state_nx_s = LEN_HI;
          end else if (s_last) begin
            drop_s     = 1'b1;
            err_s      = 1'b1;
            err_code_s = 8'h04;
            state_nx_s = LEN_HI;
          end else begin
            disc_cnt_nx_s = disc_cnt_r - 16'd1;
            state_nx_s    = DISCARD;
          end
        end
        default: begin
          state_nx_s = LEN_HI;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Framing state and captured message fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= LEN_HI;
      len_hi_r   <= 8'h00;
      len_r      <= 16'd0;
      idx_r      <= 16'd0;
      disc_cnt_r <= 16'd0;
      type_r     <= 8'h00;
      sym_r      <= 32'd0;
      val_r      <= 32'd0;
    end else begin
      state_r    <= state_nx_s;
      len_hi_r   <= len_hi_nx_s;
      len_r      <= len_nx_s;
      idx_r      <= idx_nx_s;
      disc_cnt_r <= disc_cnt_nx_s;
      type_r     <= type_nx_s;
      sym_r      <= sym_nx_s;
      val_r      <= val_nx_s;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers, storage count and the registered head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      mem_cnt_r   <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 64'd0;
      out_type_r  <= 8'h00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      mem_cnt_r <= mem_cnt_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, load_s};
      if (load_s) begin
        rd_ptr_r    <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        out_valid_r <= 1'b1;
        out_data_r  <= mem_r[rd_ptr_r][63:0];
        out_type_r  <= mem_r[rd_ptr_r][71:64];
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Message/drop counters and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_count_r  <= 32'd0;
      drop_count_r <= 16'd0;
      err_flag_r   <= 1'b0;
      err_code_r   <= 8'h00;
    end else begin
      if (push_s) begin
        msg_count_r <= msg_count_r + 32'd1;
      end
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
      err_flag_r <= err_s;
      if (err_s) begin
        err_code_r <= err_code_s;
      end
    end
  end

  assign s_ready    = s_ready_s;
  assign data_valid = out_valid_r;
  assign data_in    = out_data_r;
  assign data_type  = out_type_r;
  assign msg_count  = msg_count_r;
  assign drop_count = drop_count_r;
  assign err_flag   = err_flag_r;
  assign err_code   = err_code_r;

endmodule
